// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizes for the unified IF/MEM memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    localparam int ARB_STATE_SIZE = 2;
    localparam int MEM_DATA_SIZE  = 32;
    localparam int MEM_ADDR_SIZE  = 32;

    typedef enum logic [ARB_STATE_SIZE-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_ERR   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles a memory transaction has waited for its acknowledge.
// Latency: terminal is combinational from the registered count.
// Backpressure: none; holds its value when not enabled and never wraps.
module mem_timeout_counter #(
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    assign terminal = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Latency: grant to memReq 1 cycle; valid pulses the cycle after memAck.
// Backpressure: requests are held until valid; pipeline lockers drop to 0 while a request is pending.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = MEM_ADDR_SIZE,
    parameter int DATA_W         = MEM_DATA_SIZE,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic [DATA_W-1:0] ifData,
    output logic              ifValid,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic [DATA_W-1:0] dRdata,
    output logic              dValid,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memAck,
    output logic              PCLocker,
    output logic              IF_IDLocker,
    output logic              DECLocker,
    output logic              memTimeout
);

    localparam int BURST_W = $clog2(MAX_DATA_BURST) + 1;

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [BURST_W-1:0] burst_cnt;
    logic               data_win;
    logic               grant_d;
    logic               grant_f;
    logic               busy;
    logic               to_tc;

    // Data wins unless it has already starved a waiting fetch for a full burst.
    assign data_win = dReq && ((burst_cnt < BURST_W'(MAX_DATA_BURST)) || !ifReq);
    assign grant_d  = (state == ARB_IDLE) && data_win;
    assign grant_f  = (state == ARB_IDLE) && !data_win && ifReq;
    assign busy     = (state == ARB_FETCH) || (state == ARB_DATA);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (grant_d || grant_f),
        .enable  (busy && !memAck),
        .terminal(to_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (grant_d) begin
                    state_nxt = ARB_DATA;
                end else if (grant_f) begin
                    state_nxt = ARB_FETCH;
                end
            end
            ARB_FETCH, ARB_DATA: begin
                if (memAck) begin
                    state_nxt = ARB_IDLE;
                end else if (to_tc) begin
                    state_nxt = ARB_ERR;
                end
            end
            ARB_ERR:  state_nxt = ARB_ERR;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        PCLocker    = 1'b1;
        IF_IDLocker = 1'b1;
        DECLocker   = 1'b1;
        if (!rst_n) begin
            PCLocker    = 1'b1;
        end else if (state == ARB_ERR) begin
            PCLocker    = 1'b0;
            IF_IDLocker = 1'b0;
            DECLocker   = 1'b0;
        end else begin
            if (ifReq && !ifValid) begin
                PCLocker    = 1'b0;
                IF_IDLocker = 1'b0;
            end
            if (dReq && !dValid) begin
                PCLocker    = 1'b0;
                IF_IDLocker = 1'b0;
                DECLocker   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            ifData     <= '0;
            ifValid    <= 1'b0;
            dRdata     <= '0;
            dValid     <= 1'b0;
            memTimeout <= 1'b0;
        end else begin
            ifValid <= 1'b0;
            dValid  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        memReq   <= 1'b1;
                        memWe    <= dWe;
                        memAddr  <= dAddr;
                        memWdata <= dWdata;
                    end else if (grant_f) begin
                        memReq  <= 1'b1;
                        memWe   <= 1'b0;
                        memAddr <= ifAddr;
                    end
                end
                ARB_FETCH: begin
                    if (memAck) begin
                        memReq  <= 1'b0;
                        ifData  <= memRdata;
                        ifValid <= 1'b1;
                    end else if (to_tc) begin
                        memReq     <= 1'b0;
                        memTimeout <= 1'b1;
                    end
                end
                ARB_DATA: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        if (!memWe) begin
                            dRdata <= memRdata;
                        end
                        dValid <= 1'b1;
                    end else if (to_tc) begin
                        memReq     <= 1'b0;
                        memTimeout <= 1'b1;
                    end
                end
                default: begin
                    memReq <= 1'b0;
                end
            endcase
        end
    end

    // Burst count only matters while a fetch is actually waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (!ifReq || grant_f) begin
            burst_cnt <= '0;
        end else if (grant_d && (burst_cnt < BURST_W'(MAX_DATA_BURST))) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboarded memory model and requesters.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifData;
    logic        ifValid;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] dRdata;
    logic        dValid;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memAck;
    logic        PCLocker;
    logic        IF_IDLocker;
    logic        DECLocker;
    logic        memTimeout;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        gnt_q[$];
    txn_t        d_pend[$];
    logic [31:0] if_pend[$];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] mem_img[logic [31:0]];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ack_lat = 0;
    int          wait_cnt = 0;
    bit          mem_en = 1'b1;
    bit          stray_ack = 1'b0;
    logic        mem_req_q = 1'b0;
    txn_t        cap;
    txn_t        g_mon;
    txn_t        d_nxt;
    logic [31:0] exp_last_load = 32'h0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DATA_BURST(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifValid(ifValid),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dRdata(dRdata), .dValid(dValid),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck),
        .PCLocker(PCLocker), .IF_IDLocker(IF_IDLocker), .DECLocker(DECLocker),
        .memTimeout(memTimeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_gnt(input logic we, input logic [31:0] a, input logic [31:0] wd);
        gnt_q.push_back('{we: we, addr: a, wdata: wd});
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic [31:0] exp);
        if_pend.push_back(a);
        exp_if_q.push_back(exp);
    endtask

    task automatic push_load(input logic [31:0] a, input logic [31:0] exp);
        d_pend.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
        exp_d_q.push_back(exp);
        exp_last_load = exp;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] wd);
        d_pend.push_back('{we: 1'b1, addr: a, wdata: wd});
        exp_d_q.push_back(exp_last_load);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (((gnt_q.size() + exp_if_q.size() + exp_d_q.size() + if_pend.size() + d_pend.size()) != 0
                || ifReq || dReq) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(gnt_q.size() + exp_if_q.size() + exp_d_q.size() + int'(ifReq) + int'(dReq)), 64'd0);
    endtask

    // Memory model, grant/completion scoreboards and requester agents.
    always @(negedge clk) begin
        if (memReq && !mem_req_q) begin
            if (gnt_q.size() == 0) begin
                chk("gnt_spurious", 64'(memReq), 64'd0);
            end else begin
                g_mon = gnt_q.pop_front();
                chk("gnt_we", 64'(memWe), 64'(g_mon.we));
                chk("gnt_addr", 64'(memAddr), 64'(g_mon.addr));
                if (g_mon.we) chk("gnt_wdata", 64'(memWdata), 64'(g_mon.wdata));
            end
            cap = '{we: memWe, addr: memAddr, wdata: memWdata};
        end else if (memReq) begin
            chk("hold_we", 64'(memWe), 64'(cap.we));
            chk("hold_addr", 64'(memAddr), 64'(cap.addr));
            chk("hold_wdata", 64'(memWdata), 64'(cap.wdata));
        end
        mem_req_q = memReq;

        memAck = 1'b0;
        if (memReq && mem_en) begin
            if (wait_cnt >= ack_lat) begin
                memAck   = 1'b1;
                memRdata = mem_img.exists(memAddr) ? mem_img[memAddr] : 32'h0;
                if (memWe) mem_img[memAddr] = memWdata;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (stray_ack) begin
            memAck   = 1'b1;
            memRdata = 32'hBAD0_BAD0;
        end

        if (ifValid) begin
            if (exp_if_q.size() == 0) chk("if_spurious", 64'(ifValid), 64'd0);
            else chk("if_data", 64'(ifData), 64'(exp_if_q.pop_front()));
        end
        if (dValid) begin
            if (exp_d_q.size() == 0) chk("d_spurious", 64'(dValid), 64'd0);
            else chk("d_rdata", 64'(dRdata), 64'(exp_d_q.pop_front()));
        end

        if (ifValid || !ifReq) begin
            if (if_pend.size() != 0) begin
                ifReq  = 1'b1;
                ifAddr = if_pend.pop_front();
            end else begin
                ifReq = 1'b0;
            end
        end
        if (dValid || !dReq) begin
            if (d_pend.size() != 0) begin
                d_nxt  = d_pend.pop_front();
                dReq   = 1'b1;
                dWe    = d_nxt.we;
                dAddr  = d_nxt.addr;
                dWdata = d_nxt.wdata;
            end else begin
                dReq = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        rst_n = 1'b1; ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dWe = 1'b0;
        dAddr = '0; dWdata = '0; memRdata = '0; memAck = 1'b0;
        mem_img[32'h100]  = 32'h0050_0093;
        mem_img[32'h300]  = 32'h0000_0013;
        mem_img[32'h400]  = 32'h00A0_0113;
        mem_img[32'h2000] = 32'hCAFE_0001;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_memReq", 64'(memReq), 64'd0);
        chk("rst_memWe", 64'(memWe), 64'd0);
        chk("rst_memAddr", 64'(memAddr), 64'd0);
        chk("rst_memWdata", 64'(memWdata), 64'd0);
        chk("rst_valids", 64'({ifValid, dValid}), 64'd0);
        chk("rst_ifData", 64'(ifData), 64'd0);
        chk("rst_dRdata", 64'(dRdata), 64'd0);
        chk("rst_timeout", 64'(memTimeout), 64'd0);
        chk("rst_lockers", 64'({PCLocker, IF_IDLocker, DECLocker}), 64'h7);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Fetch only, zero-wait memory
        ack_lat = 0;
        push_gnt(1'b0, 32'h100, 32'h0);
        push_fetch(32'h100, 32'h0050_0093);
        step();
        chk("t1_G_lockers", 64'({PCLocker, IF_IDLocker, DECLocker}), 64'h1);
        chk("t1_G_memReq", 64'(memReq), 64'd0);
        step();
        chk("t1_G1_memReq", 64'(memReq), 64'd1);
        chk("t1_G1_memAddr", 64'(memAddr), 64'h100);
        chk("t1_G1_lockers", 64'({PCLocker, IF_IDLocker}), 64'h0);
        chk("t1_G1_ifValid", 64'(ifValid), 64'd0);
        step();
        chk("t1_G2_ifValid", 64'(ifValid), 64'd1);
        chk("t1_G2_ifData", 64'(ifData), 64'h0050_0093);
        chk("t1_G2_lockers", 64'({PCLocker, IF_IDLocker}), 64'h3);
        drain("t1_drain", 10);

        // Simultaneous fetch and load: data first, fetch granted in the dValid cycle
        ack_lat = 3;
        push_gnt(1'b0, 32'h2000, 32'h0);
        push_gnt(1'b0, 32'h300, 32'h0);
        push_load(32'h2000, 32'hCAFE_0001);
        push_fetch(32'h300, 32'h0000_0013);
        n = 0;
        step();
        while (!dValid && n < 20) begin
            chk("t2_dec_hold", 64'(DECLocker), 64'd0);
            step();
            n++;
        end
        chk("t2_wait_cycles", 64'(n), 64'd5);
        chk("t2_dValid", 64'(dValid), 64'd1);
        chk("t2_dRdata", 64'(dRdata), 64'hCAFE_0001);
        chk("t2_dec_free", 64'(DECLocker), 64'd1);
        step();
        chk("t2_fetch_gnt", 64'({memReq, memWe}), 64'h2);
        chk("t2_fetch_addr", 64'(memAddr), 64'h300);
        drain("t2_drain", 20);

        // Five stores with a fetch held: D,D,D,D,F,D
        ack_lat = 0;
        for (int i = 0; i < 4; i++) push_gnt(1'b1, 32'h80 + 32'(4 * i), 32'(i + 1));
        push_gnt(1'b0, 32'h400, 32'h0);
        push_gnt(1'b1, 32'h90, 32'd5);
        push_fetch(32'h400, 32'h00A0_0113);
        for (int i = 0; i < 5; i++) push_store(32'h80 + 32'(4 * i), 32'(i + 1));
        drain("t3_drain", 60);
        chk("t3_store_img", 64'(mem_img[32'h8C]), 64'd4);

        // Single store with wait states
        ack_lat = 2;
        push_gnt(1'b1, 32'h40, 32'hDEAD_BEEF);
        push_store(32'h40, 32'hDEAD_BEEF);
        n = 0;
        while (!memReq && n < 10) begin step(); n++; end
        chk("t4_memWe", 64'(memWe), 64'd1);
        chk("t4_memAddr", 64'(memAddr), 64'h40);
        chk("t4_memWdata", 64'(memWdata), 64'hDEAD_BEEF);
        drain("t4_drain", 20);
        chk("t4_dRdata_kept", 64'(dRdata), 64'hCAFE_0001);
        chk("t4_store_img", 64'(mem_img[32'h40]), 64'hDEAD_BEEF);

        // Memory never acknowledges
        mem_en = 1'b0;
        push_gnt(1'b0, 32'h500, 32'h0);
        if_pend.push_back(32'h500);
        n = 0;
        while (!memReq && n < 10) begin step(); n++; end
        cnt = 0;
        while (memReq && cnt < 30) begin cnt++; step(); end
        chk("t5_req_cycles", 64'(cnt), 64'd8);
        chk("t5_timeout", 64'(memTimeout), 64'd1);
        chk("t5_memReq", 64'(memReq), 64'd0);
        chk("t5_lockers", 64'({PCLocker, IF_IDLocker, DECLocker}), 64'h0);
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        step();
        chk("t5_stray_ifValid", 64'(ifValid), 64'd0);
        chk("t5_stray_state", 64'({memReq, memTimeout, PCLocker}), 64'h2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_timeout", 64'(memTimeout), 64'd0);
        chk("t5_rst_lockers", 64'({PCLocker, IF_IDLocker, DECLocker}), 64'h7);
        chk("t5_rst_data", 64'({ifData, dRdata}), 64'd0);
        ifReq = 1'b0;
        if_pend.delete();
        exp_last_load = 32'h0;
        mem_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Asynchronous reset in the middle of a load
        ack_lat = 5;
        push_gnt(1'b0, 32'h2000, 32'h0);
        d_pend.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h0});
        n = 0;
        while (!memReq && n < 10) begin step(); n++; end
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_memReq", 64'(memReq), 64'd0);
        chk("t6_rst_lockers", 64'({dReq, PCLocker, DECLocker}), 64'h7);
        dReq = 1'b0;
        d_pend.delete();
        exp_last_load = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (dValid) cnt++;
            step();
        end
        chk("t6_no_dValid", 64'(cnt), 64'd0);
        ack_lat = 0;
        push_gnt(1'b0, 32'h2000, 32'h0);
        push_load(32'h2000, 32'hCAFE_0001);
        drain("t6_drain", 20);
        chk("t6_final_timeout", 64'(memTimeout), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
